tx_frm_sync_wide: RTL

Frame-boundary synchroniser for the TX path, generalised over buffer depth, datapath width and header layout. It sits between the TX frame buffer's read side and the MAC-side frame reader, and parses the length field of each frame header at the read pointer. It signals the reader when a whole frame (header plus payload) is committed (`trig`), and when enough data is committed for cut-through streaming (`rsk`). With length checking compiled in, it also flags malformed frames for discard (`drop`) instead of stalling the buffer.

---
 rtl/tx_frm_sync_wide_if.sv | 29 ++
 rtl/tx_frm_sync_wide.sv | 139 +++++++++++++
 2 files changed

// File: rtl/tx_frm_sync_wide_if.sv
// Read-side handshake between the TX frame buffer, the frame-boundary
// synchroniser (slave) and the MAC-side frame reader (master).
interface tx_frm_sync_wide_if #(
  parameter int BW = 9,
  parameter int DW = 64
);
  localparam int BPW = DW / 8;

  logic [BW:0]     rd_addr;
  logic [DW-1:0]   rd_data;
  logic [BW:0]     committed_prod;
  logic            trig;
  logic [13:0]     wd_len;
  logic [BPW-1:0]  lst_ben;
  logic            rsk;
  logic            rsk_tk;
  logic            sync;
  logic            drop;

  modport master (
    output rd_addr, rd_data, committed_prod, rsk_tk, sync,
    input  trig, wd_len, lst_ben, rsk, drop
  );

  modport slave (
    input  rd_addr, rd_data, committed_prod, rsk_tk, sync,
    output trig, wd_len, lst_ben, rsk, drop
  );
endinterface

// File: rtl/tx_frm_sync_wide.sv
// TX frame-boundary synchroniser: parses the header length at the read pointer
// and reports whole-frame (trig) / cut-through (rsk) readiness.
// Optional length checking with drop pulses: define TX_FRM_SYNC_LEN_CHECK_EN.
module tx_frm_sync_wide #(
  parameter int BW        = 9,
  parameter int DW        = 64,
  parameter int LEN_LSB   = 32,
  parameter int RSK_TH    = 16,
  parameter int MAX_BYTES = 9600
) (
  input  logic               clk,
  input  logic               rst,
  tx_frm_sync_wide_if.slave  bus
);
  localparam int BPW = DW / 8;
  localparam int LB  = $clog2(BPW);

  typedef enum logic [3:0] {
    S_INIT = 4'b0001,
    S_HDR  = 4'b0010,
    S_EVAL = 4'b0100,
    S_BUSY = 4'b1000
  } state_t;

  function automatic logic [13:0] words_of(input logic [15:0] l);
    return 14'(l >> LB) + 14'(l[LB-1:0] != '0);
  endfunction

  function automatic logic [BPW-1:0] ben_of(input logic [LB-1:0] rem);
    logic [BPW-1:0] b;
    b = '1;
    if (rem != '0) b = (BPW'(1) << rem) - BPW'(1);
    return b;
  endfunction

  state_t          state, nxt;
  logic [BW:0]     diff_p0;
  logic [15:0]     len_p0;
  logic [13:0]     wd_len_c;
  logic [BPW-1:0]  lst_ben_c;
  logic            fits_c;
  logic            illegal_c;
  logic            trig_c, drop_c, eval_c, cap_c;
  logic            trig_p1, drop_p1, rsk_p1;
  logic [13:0]     wd_len_p1;
  logic [BPW-1:0]  lst_ben_p1;
  logic            unused_data;

  assign unused_data = ^bus.rd_data;

  assign wd_len_c  = words_of(len_p0);
  assign lst_ben_c = ben_of(len_p0[LB-1:0]);
  // diff never exceeds 2^BW, so a frame of 2^BW or more words can never fit
  assign fits_c    = int'(diff_p0) > int'(wd_len_c);

`ifdef TX_FRM_SYNC_LEN_CHECK_EN
  assign illegal_c = (len_p0 == 16'd0) || (int'(len_p0) > MAX_BYTES) ||
                     (int'(wd_len_c) >= (1 << BW));
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_BYTES == 0);
  assign illegal_c  = 1'b0;
`endif

  // ---- stage p0: pointer distance and header capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 diff_p0 <= '0;
    else if (state == S_INIT) diff_p0 <= '0;
    else                     diff_p0 <= bus.committed_prod - bus.rd_addr;
  end

  always_ff @(posedge clk) begin
    if (cap_c) len_p0 <= bus.rd_data[LEN_LSB+15:LEN_LSB];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = S_INIT;
    case (state)
      S_INIT: nxt = S_HDR;
      S_HDR:  nxt = (diff_p0 != '0) ? S_EVAL : S_HDR;
      S_EVAL: begin
        if (bus.rsk_tk || illegal_c || fits_c) nxt = S_BUSY;
        else                                   nxt = S_HDR;
      end
      S_BUSY: nxt = bus.sync ? S_EVAL : S_BUSY;
      default: nxt = S_INIT;
    endcase
  end

  always_comb begin
    trig_c = 1'b0;
    drop_c = 1'b0;
    eval_c = 1'b0;
    cap_c  = 1'b0;
    case (state)
      S_HDR, S_BUSY: cap_c = 1'b1;
      S_EVAL: begin
        eval_c = 1'b1;
        drop_c = !bus.rsk_tk && illegal_c;
        trig_c = !bus.rsk_tk && !illegal_c && fits_c;
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered pulses and frame geometry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_p1    <= 1'b0;
      drop_p1    <= 1'b0;
      rsk_p1     <= 1'b0;
      wd_len_p1  <= '0;
      lst_ben_p1 <= '1;
    end else begin
      trig_p1 <= trig_c;
      drop_p1 <= drop_c;
      rsk_p1  <= int'(diff_p0) >= RSK_TH;
      if (eval_c) begin
        wd_len_p1  <= wd_len_c;
        lst_ben_p1 <= lst_ben_c;
      end
    end
  end

  assign bus.trig    = trig_p1;
  assign bus.rsk     = rsk_p1;
  assign bus.wd_len  = wd_len_p1;
  assign bus.lst_ben = lst_ben_p1;
`ifdef TX_FRM_SYNC_LEN_CHECK_EN
  assign bus.drop    = drop_p1;
`else
  assign bus.drop    = 1'b0;
`endif
endmodule
